// File: rtl/element_delay_accumulator.sv
// -----------------------------------------------------------------------------
// element_delay_accumulator
//
// Purpose:
//   Integrates the per-element comparator terms K_n (positive and negative
//   side) into running errors. It then walks an integer sample-delay counter
//   per side, Bresenham-style, until each error is back inside its bounds.
//   It emits one delay pair per element index to the delay-line stage.
//
// Optional build macro:
//   DELAY_CLAMP_EN - saturate delays at 0 and 2^DW_DELAY-1 instead of
//                    wrapping. Adds the sticky clamp_hit output.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   initiate          - start a run (IDLE only); samples delay_init
//   delay_init        - centre delay d0 in samples
//   term_pos_n        - signed K_n, positive-side element
//   term_neg_n        - signed K_n, negative-side element
//   term_ready        - term pair valid
//   term_last         - current term pair is the last of the run
//   term_ack          - one-cycle pulse: term pair consumed
//   delay_pos         - delay of positive-side element n
//   delay_neg         - delay of negative-side element n
//   element_index     - index n of the current output pair
//   delay_valid       - output pair valid
//   delay_ack         - downstream consumed the output pair
//   step_overflow     - sticky per run: an element exceeded MAX_STEPS steps
//   busy              - high in any state other than IDLE
//   clamp_hit         - (DELAY_CLAMP_EN only) sticky: a delay saturated
//
// States:
//   state       | meaning
//   S_IDLE      | waiting for initiate
//   S_WAIT_TERM | waiting for the next term pair
//   S_ADJUST    | one Bresenham step per cycle on both sides
//   S_OUTPUT    | presenting the delay pair until delay_ack
// -----------------------------------------------------------------------------
module element_delay_accumulator #(
    parameter int DW_INTEGER   = 18,
    parameter int DW_FRACTION  = 6,
    parameter int DW_DELAY     = 13,
    parameter int NUM_ELEMENTS = 64,
    parameter int MAX_STEPS    = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      initiate,
    input  logic [DW_DELAY-1:0]                       delay_init,
    input  logic signed [DW_INTEGER+DW_FRACTION-1:0]  term_pos_n,
    input  logic signed [DW_INTEGER+DW_FRACTION-1:0]  term_neg_n,
    input  logic                                      term_ready,
    input  logic                                      term_last,
    output logic                                      term_ack,
    output logic [DW_DELAY-1:0]                       delay_pos,
    output logic [DW_DELAY-1:0]                       delay_neg,
    output logic [$clog2(NUM_ELEMENTS)-1:0]           element_index,
    output logic                                      delay_valid,
    input  logic                                      delay_ack,
    output logic                                      step_overflow,
`ifdef DELAY_CLAMP_EN
    output logic                                      clamp_hit,
`endif
    output logic                                      busy
);

    localparam int TW = DW_INTEGER + DW_FRACTION;
    localparam int EW = TW + 2;
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int IW = $clog2(NUM_ELEMENTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TERM,
        S_ADJUST,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic signed [EW-1:0] e_p, e_n;
    logic [DW_DELAY-1:0]  d_p, d_n;
    logic [IW-1:0]        index;
    logic [SW-1:0]        step_cnt;
    logic                 last_q;

    logic signed [EW-1:0] thr_up_p, thr_up_n;
    logic signed [EW-1:0] thr_dn_p, thr_dn_n;
    logic                 up_p, up_n, dn_p, dn_n;
    logic                 move_up_p, move_up_n, move_dn_p, move_dn_n;
    logic                 settled_p, settled_n;
    logic                 step_limit;
`ifdef DELAY_CLAMP_EN
    logic                 clip_p, clip_n;
`endif

    // Step decision for both sides. Thresholds are (2d+1) and (2d-1) scaled
    // into the term fraction alignment; 2d-1 is formed modulo 2^EW so d=0
    // yields -1 and the decrement bound becomes +1<<DW_FRACTION.
    always_comb begin
        thr_up_p = EW'({d_p, 1'b1}) << DW_FRACTION;
        thr_up_n = EW'({d_n, 1'b1}) << DW_FRACTION;
        thr_dn_p = (EW'({d_p, 1'b0}) - EW'(1)) << DW_FRACTION;
        thr_dn_n = (EW'({d_n, 1'b0}) - EW'(1)) << DW_FRACTION;
        up_p     = (e_p >= thr_up_p);
        up_n     = (e_n >= thr_up_n);
        dn_p     = (e_p <= -thr_dn_p);
        dn_n     = (e_n <= -thr_dn_n);
`ifdef DELAY_CLAMP_EN
        clip_p    = (up_p && (d_p == '1)) || (!up_p && dn_p && (d_p == '0));
        clip_n    = (up_n && (d_n == '1)) || (!up_n && dn_n && (d_n == '0));
        move_up_p = up_p && (d_p != '1);
        move_up_n = up_n && (d_n != '1);
        move_dn_p = !up_p && dn_p && (d_p != '0);
        move_dn_n = !up_n && dn_n && (d_n != '0);
`else
        move_up_p = up_p;
        move_up_n = up_n;
        move_dn_p = !up_p && dn_p;
        move_dn_n = !up_n && dn_n;
`endif
        settled_p  = !move_up_p && !move_dn_p;
        settled_n  = !move_up_n && !move_dn_n;
        step_limit = (step_cnt == SW'(MAX_STEPS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (initiate)   state_nxt = S_WAIT_TERM;
            S_WAIT_TERM: if (term_ready) state_nxt = S_ADJUST;
            S_ADJUST: begin
                if ((settled_p && settled_n) || step_limit) state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (delay_ack) state_nxt = last_q ? S_IDLE : S_WAIT_TERM;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_p           <= '0;
            e_n           <= '0;
            d_p           <= '0;
            d_n           <= '0;
            index         <= '0;
            step_cnt      <= '0;
            last_q        <= 1'b0;
            step_overflow <= 1'b0;
`ifdef DELAY_CLAMP_EN
            clamp_hit     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (initiate) begin
                        d_p           <= delay_init;
                        d_n           <= delay_init;
                        e_p           <= '0;
                        e_n           <= '0;
                        index         <= '0;
                        step_overflow <= 1'b0;
`ifdef DELAY_CLAMP_EN
                        clamp_hit     <= 1'b0;
`endif
                    end
                end
                S_WAIT_TERM: begin
                    if (term_ready) begin
                        e_p      <= e_p + {{2{term_pos_n[TW-1]}}, term_pos_n};
                        e_n      <= e_n + {{2{term_neg_n[TW-1]}}, term_neg_n};
                        last_q   <= term_last;
                        step_cnt <= '0;
                    end
                end
                S_ADJUST: begin
`ifdef DELAY_CLAMP_EN
                    if (clip_p || clip_n) clamp_hit <= 1'b1;
`endif
                    if (!(settled_p && settled_n)) begin
                        if (step_limit) begin
                            // Give up on this element and emit current values.
                            step_overflow <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                            if (move_up_p) begin
                                e_p <= e_p - thr_up_p;
                                d_p <= d_p + DW_DELAY'(1);
                            end else if (move_dn_p) begin
                                e_p <= e_p + thr_dn_p;
                                d_p <= d_p - DW_DELAY'(1);
                            end
                            if (move_up_n) begin
                                e_n <= e_n - thr_up_n;
                                d_n <= d_n + DW_DELAY'(1);
                            end else if (move_dn_n) begin
                                e_n <= e_n + thr_dn_n;
                                d_n <= d_n - DW_DELAY'(1);
                            end
                        end
                    end
                end
                S_OUTPUT: begin
                    if (delay_ack && !last_q) index <= index + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // d_p/d_n are frozen in S_OUTPUT, so the delay outputs hold until delay_ack.
    always_comb begin
        term_ack      = (state == S_WAIT_TERM) && term_ready;
        delay_valid   = (state == S_OUTPUT);
        busy          = (state != S_IDLE);
        delay_pos     = d_p;
        delay_neg     = d_n;
        element_index = index;
    end

endmodule
